// File: rtl/aes_edn_arb.sv
// N-way arbiter sharing one EDN request/ack/data channel among AES entropy consumers.
// Handshake: a consumer holds req_i until it sees its one-cycle ack_o; edn_req_o stays high until edn_ack_i.
module aes_edn_arb #(
  parameter int NumReq     = 2,
  parameter int Width      = 32,
  parameter int RoundRobin = 0,
  parameter int CntWidth   = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  output logic [NumReq-1:0]   ack_o,
  output logic [Width-1:0]    data_o,
  input  logic                escalate_i,
  output logic                edn_req_o,
  input  logic                edn_ack_i,
  input  logic [Width-1:0]    edn_data_i,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic [CntWidth-1:0] drop_cnt_o,
  output logic                err_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_BUSY   = 4'b0010,
    S_ORPHAN = 4'b0100,
    S_HALT   = 4'b1000
  } state_e;

  state_e              r_state;
  logic [NumReq-1:0]   r_grant;
  logic [PtrW-1:0]     r_win;
  logic [PtrW-1:0]     r_ptr;
  logic                r_edn_req;
  logic                r_esc_seen;
  logic                r_err;
  logic [CntWidth-1:0] r_drop;

  logic                w_found;
  int                  w_idx;
  logic [PtrW-1:0]     w_cand;
  logic [PtrW-1:0]     w_win;
  logic [NumReq-1:0]   w_win_oh;
  logic                w_req_g;
  logic                w_fwd;
  logic [CntWidth-1:0] w_drop_inc;
  logic [PtrW-1:0]     w_ptr_nxt;

  // Search starts at r_ptr in round-robin mode and at 0 in fixed-priority mode.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_idx = (RoundRobin != 0) ? (int'(r_ptr) + i) : i;
      if (w_idx >= NumReq) w_idx = w_idx - NumReq;
      w_cand = PtrW'(w_idx);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_win_oh   = NumReq'(1) << w_win;
  assign w_req_g    = |(req_i & r_grant);
  assign w_fwd      = (r_state == S_BUSY) && edn_ack_i && w_req_g && !escalate_i;
  assign w_drop_inc = (&r_drop) ? r_drop : r_drop + 1'b1;
  assign w_ptr_nxt  = (r_win == PtrW'(NumReq - 1)) ? '0 : r_win + 1'b1;

  assign ack_o      = w_fwd ? r_grant : '0;
  assign data_o     = w_fwd ? edn_data_i : '0;
  assign edn_req_o  = r_edn_req;
  assign busy_o     = r_edn_req;
  assign grant_o    = r_grant;
  assign halted_o   = (r_state == S_HALT);
  assign drop_cnt_o = r_drop;
  assign err_o      = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_win      <= '0;
      r_ptr      <= '0;
      r_edn_req  <= 1'b0;
      r_esc_seen <= 1'b0;
      r_err      <= 1'b0;
      r_drop     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (edn_ack_i) r_err <= 1'b1;
          if (escalate_i) begin
            r_state <= S_HALT;
          end else if (w_found) begin
            r_state   <= S_BUSY;
            r_grant   <= w_win_oh;
            r_win     <= w_win;
            r_edn_req <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_fwd) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_edn_req <= 1'b0;
            r_ptr     <= w_ptr_nxt;
          end else if (edn_ack_i) begin
            // Owner withdrew or escalation arrived in the same cycle as the ack.
            r_drop    <= w_drop_inc;
            r_grant   <= '0;
            r_edn_req <= 1'b0;
            r_state   <= escalate_i ? S_HALT : S_IDLE;
          end else if (!w_req_g || escalate_i) begin
            r_state    <= S_ORPHAN;
            r_grant    <= '0;
            r_esc_seen <= escalate_i;
          end
        end
        S_ORPHAN: begin
          if (escalate_i) r_esc_seen <= 1'b1;
          if (edn_ack_i) begin
            r_drop     <= w_drop_inc;
            r_edn_req  <= 1'b0;
            r_esc_seen <= 1'b0;
            r_state    <= (r_esc_seen || escalate_i) ? S_HALT : S_IDLE;
          end
        end
        S_HALT: begin
          if (edn_ack_i) r_err <= 1'b1;
          r_grant   <= '0;
          r_edn_req <= 1'b0;
        end
        default: begin
          r_state   <= S_HALT;
          r_err     <= 1'b1;
          r_grant   <= '0;
          r_edn_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_edn_arb.sv
// Bench for aes_edn_arb: a fixed-priority instance (CntWidth=2) and a round-robin instance,
// with an ack scoreboard per instance and directed sequences.
module tb_aes_edn_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Fixed-priority instance
  logic [2:0]  f_req = '0, f_ack, f_grant;
  logic        f_esc = 1'b0, f_eack = 1'b0, f_ereq, f_busy, f_halt, f_err;
  logic [31:0] f_edata = '0, f_data;
  logic [1:0]  f_drop;

  // Round-robin instance
  logic [2:0]  r_req = '0, r_ack, r_grant;
  logic        r_esc = 1'b0, r_eack = 1'b0, r_ereq, r_busy, r_halt, r_err;
  logic [31:0] r_edata = '0, r_data;
  logic [7:0]  r_drop;

  aes_edn_arb #(.NumReq(3), .Width(32), .RoundRobin(0), .CntWidth(2)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(f_req), .ack_o(f_ack), .data_o(f_data),
    .escalate_i(f_esc), .edn_req_o(f_ereq), .edn_ack_i(f_eack), .edn_data_i(f_edata),
    .grant_o(f_grant), .busy_o(f_busy), .halted_o(f_halt), .drop_cnt_o(f_drop), .err_o(f_err)
  );

  aes_edn_arb #(.NumReq(3), .Width(32), .RoundRobin(1), .CntWidth(8)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_i(r_req), .ack_o(r_ack), .data_o(r_data),
    .escalate_i(r_esc), .edn_req_o(r_ereq), .edn_ack_i(r_eack), .edn_data_i(r_edata),
    .grant_o(r_grant), .busy_o(r_busy), .halted_o(r_halt), .drop_cnt_o(r_drop), .err_o(r_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fp_drop  = 0;
  logic [34:0] exp_fp_q[$];
  logic [34:0] exp_rr_q[$];
  logic [34:0] e_fp, e_rr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitors: pop an expected {ack,data} whenever an ack is presented.
  always @(negedge clk) begin
    if (|f_ack) begin
      if (exp_fp_q.size() == 0) begin
        chk("fp_unexpected_ack", {f_ack, f_data}, 35'h0);
      end else begin
        e_fp = exp_fp_q.pop_front();
        chk("fp_ack_data", {f_ack, f_data}, e_fp);
      end
    end else begin
      chk("fp_data_idle_zero", f_data, 32'h0);
    end
  end

  always @(negedge clk) begin
    if (|r_ack) begin
      if (exp_rr_q.size() == 0) begin
        chk("rr_unexpected_ack", {r_ack, r_data}, 35'h0);
      end else begin
        e_rr = exp_rr_q.pop_front();
        chk("rr_ack_data", {r_ack, r_data}, e_rr);
      end
    end else begin
      chk("rr_data_idle_zero", r_data, 32'h0);
    end
  end

  // EDN responder: wait for edn_req, check owner, expect a forwarded ack, reply after dly cycles.
  task automatic serve_fp(input logic [2:0] g, input logic [31:0] d, input int dly);
    int n = 0;
    @(negedge clk);
    while (!f_ereq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fp_wait_edn_req", f_ereq, 1'b1);
    chk("fp_grant", f_grant, g);
    exp_fp_q.push_back({g, d});
    repeat (dly) @(posedge clk);
    #1;
    f_eack = 1'b1; f_edata = d;
    step();
    f_eack = 1'b0; f_edata = '0;
    chk("fp_ack_seen", exp_fp_q.size(), 0);
  endtask

  task automatic serve_rr(input logic [2:0] g, input logic [31:0] d, input int dly);
    int n = 0;
    @(negedge clk);
    while (!r_ereq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rr_wait_edn_req", r_ereq, 1'b1);
    chk("rr_grant", r_grant, g);
    exp_rr_q.push_back({g, d});
    repeat (dly) @(posedge clk);
    #1;
    r_eack = 1'b1; r_edata = d;
    step();
    r_eack = 1'b0; r_edata = '0;
    chk("rr_ack_seen", exp_rr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    repeat (3) sample();
    chk("rst_fp_outputs", {f_ack, f_ereq, f_grant, f_busy, f_halt, f_drop, f_err}, 0);
    chk("rst_rr_outputs", {r_ack, r_ereq, r_grant, r_busy, r_halt, r_drop, r_err}, 0);
    step();
    rst_n = 1'b1;
    step();

    // Fixed priority: 3'b110 -> channel 1 first, latency 1 cycle.
    f_req = 3'b110;
    sample();
    chk("fp_latency_same_cycle", f_ereq, 1'b0);
    step();
    sample();
    chk("fp_latency_one_cycle", f_ereq, 1'b1);
    serve_fp(3'b010, 32'hDEADBEEF, 4);
    f_req = 3'b100;
    step();
    sample();
    chk("fp_grant_ch2", f_grant, 3'b100);
    f_req = 3'b101;
    step();
    sample();
    chk("fp_grant_locked", f_grant, 3'b100);
    serve_fp(3'b100, 32'h12345678, 2);
    f_req = 3'b001;
    serve_fp(3'b001, 32'hCAFEF00D, 1);
    f_req = 3'b000;
    step();

    // Owner withdraws mid-BUSY: edn_req held, ack swallowed, pending channel 1 follows.
    f_req = 3'b011;
    step();
    sample();
    chk("fp_orphan_grant0", f_grant, 3'b001);
    step();
    f_req = 3'b010;
    step();
    sample();
    chk("fp_orphan_grant_released", f_grant, 3'b000);
    chk("fp_orphan_edn_req_held", f_ereq, 1'b1);
    step();
    f_eack = 1'b1; f_edata = 32'hBAD0BAD0;
    sample();
    chk("fp_orphan_no_ack", f_ack, 3'b000);
    step();
    f_eack = 1'b0; f_edata = '0;
    fp_drop = 1;
    sample();
    chk("fp_orphan_drop_cnt", f_drop, fp_drop);
    chk("fp_orphan_edn_req_low", f_ereq, 1'b0);
    serve_fp(3'b010, 32'h00001111, 2);
    f_req = 3'b000;

    // Spurious ack in IDLE sets sticky err.
    step();
    f_eack = 1'b1; f_edata = 32'h77777777;
    sample();
    chk("fp_spurious_no_ack", f_ack, 3'b000);
    step();
    f_eack = 1'b0; f_edata = '0;
    sample();
    chk("fp_err_set", f_err, 1'b1);
    repeat (3) step();
    sample();
    chk("fp_err_sticky", f_err, 1'b1);

    // Seven orphans with a 2-bit counter; alternate ack-in-ORPHAN and ack-with-withdrawal.
    for (int i = 0; i < 7; i++) begin
      f_req = 3'b001;
      step();
      f_req = 3'b000;
      if (i % 2 == 1) begin
        f_eack = 1'b1;
        step();
      end else begin
        step();
        f_eack = 1'b1;
        step();
      end
      f_eack = 1'b0;
      fp_drop = (fp_drop == 3) ? 3 : fp_drop + 1;
      sample();
      chk("fp_drop_saturate", f_drop, fp_drop);
    end

    // Round robin: 7 transactions with all channels requesting.
    r_req = 3'b111;
    for (int i = 0; i < 7; i++) begin
      serve_rr(3'(1 << (i % 3)), 32'hA0000000 + i, 1);
    end

    // Escalation mid-BUSY on channel 1: hold edn_req to the ack, swallow it, then halt.
    step();
    sample();
    chk("rr_esc_grant", r_grant, 3'b010);
    step();
    r_esc = 1'b1;
    step();
    sample();
    chk("rr_esc_edn_req_held", r_ereq, 1'b1);
    chk("rr_esc_grant_released", r_grant, 3'b000);
    step();
    r_eack = 1'b1; r_edata = 32'hFFFF0000;
    sample();
    chk("rr_esc_no_ack", r_ack, 3'b000);
    step();
    r_eack = 1'b0; r_edata = '0;
    sample();
    chk("rr_halted", r_halt, 1'b1);
    chk("rr_halt_edn_req", r_ereq, 1'b0);
    chk("rr_esc_drop_cnt", r_drop, 8'd1);
    repeat (3) step();
    sample();
    chk("rr_halt_hold", {r_halt, r_ereq, r_grant}, 5'b10000);

    // Asynchronous reset in the middle of a BUSY transaction.
    f_req = 3'b001;
    step();
    sample();
    chk("fp_busy_before_reset", f_busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("fp_async_reset", {f_ack, f_ereq, f_grant, f_busy, f_halt, f_drop, f_err}, 0);
    chk("rr_async_reset", {r_halt, r_ereq, r_grant, r_drop}, 0);
    f_req = '0; r_req = '0; r_esc = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    // Pointer was 1 before reset; a fresh pointer must pick channel 0.
    r_req = 3'b111;
    serve_rr(3'b001, 32'h5A5A5A5A, 1);
    r_req = '0;
    repeat (2) step();

    chk("fp_queue_empty", exp_fp_q.size(), 0);
    chk("rr_queue_empty", exp_rr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_edn_arb.md
Name: aes_edn_arb

Overview:
- Parametrised N-way arbiter that lets several entropy consumers inside the AES subsystem (clearing PRNG, masking PRNG, future consumers) share one EDN request/ack/data channel.
- Sits between the consumers and the EDN clock-domain synchroniser, in the clk_i domain.
- Generalises a fixed two-requester OR/priority scheme. It adds selectable fixed-priority or round-robin arbitration, a grant that stays locked per transaction, and hold-until-ack when a requester withdraws.
- Also adds escalation-driven halt, a saturating count of dropped transactions, and a sticky error for spurious acks.

Parameters:
- NumReq, 2, number of requesting channels (2..8).
- Width, 32, EDN data width in bits.
- RoundRobin, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- CntWidth, 8, width of the saturating dropped-transaction counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-channel entropy request, level, held until ack
- ack_o  out  NumReq  per-channel ack, one-cycle pulse
- data_o  out  Width  entropy word, valid in the cycle of any ack_o bit
- escalate_i  in  1  escalation or fatal alert, level
- edn_req_o  out  1  request toward EDN synchroniser, registered
- edn_ack_i  in  1  ack from EDN synchroniser, one-cycle pulse
- edn_data_i  in  Width  entropy data, valid with edn_ack_i
- grant_o  out  NumReq  one-hot current owner, zero when none
- busy_o  out  1  transaction outstanding (edn_req_o asserted)
- halted_o  out  1  arbiter in terminal halt
- drop_cnt_o  out  CntWidth  saturating count of orphaned transactions
- err_o  out  1  sticky, set on ack received with no outstanding request

Behaviour:
- Reset: rst_ni is asynchronous active-low; clock is clk_i. On reset all outputs are 0, state is IDLE, round-robin pointer is 0, drop_cnt is 0, err is 0.
- States: IDLE, BUSY, ORPHAN, HALT. Encoding is sparse. An invalid encoding goes to HALT and sets err_o.
- IDLE:
  - escalate_i=1 -> HALT, regardless of requests.
  - Else if any req_i: pick a winner, register grant_q, go to BUSY.
  - edn_req_o and grant_o assert in the next cycle. Latency from req_i rising to edn_req_o is 1 cycle.
- Winner selection:
  - Fixed priority: lowest set index.
  - Round-robin: first set index searching upward from ptr, wrapping at NumReq-1 -> 0.
  - ptr <= winner+1 (mod NumReq), updated when the transaction completes with an ack forwarded.
  - Orphaned transactions do not advance ptr.
- BUSY:
  - edn_ack_i=1 and req_i[grant]=1 and escalate_i=0: ack_o[grant]=1 and data_o=edn_data_i in the same cycle (combinational). Then -> IDLE, or -> HALT if escalate_i rises the next cycle per the IDLE rule.
  - req_i[grant]=0 without ack -> ORPHAN. Grant is released; edn_req_o stays high.
  - escalate_i=1 without ack -> ORPHAN.
  - edn_ack_i=1 in the same cycle that req_i[grant] drops or escalate_i rises: no ack_o, drop_cnt++, then -> IDLE (or HALT if escalate_i=1).
- ORPHAN:
  - edn_req_o stays high and ack_o is all 0.
  - On edn_ack_i: drop_cnt++, data discarded, then -> HALT if escalate_i was seen since entry, else IDLE.
  - Escalation seen in BUSY or ORPHAN is latched.
- HALT: terminal until reset. edn_req_o=0, ack_o=0, grant_o=0, halted_o=1. New requests are ignored.
- Only one EDN transaction is outstanding at any time. edn_req_o never deasserts before edn_ack_i once asserted, including during escalation.
- A grant never changes while BUSY, even if a higher-priority request arrives.
- drop_cnt saturates at 2^CntWidth-1.
- edn_ack_i in IDLE or HALT: ignored, err_o set (sticky until reset).
- data_o equals edn_data_i whenever an ack_o bit is set, and is 0 otherwise (no data leakage to non-owners).
- At most one ack_o bit is set per cycle; ack_o is always a subset of grant_o.

Test Plan:
- NumReq=3, RoundRobin=0; req_i=3'b110 held; EDN acks 4 cycles after edn_req_o -> grant_o=3'b010, ack_o[1] pulses with data_o=edn_data_i (e.g. 32'hDEADBEEF); then channel 2 is served; edn_req_o rises exactly 1 cycle after req_i.
- RoundRobin=1, req_i=3'b111 held for 6 transactions -> grant order 0,1,2,0,1,2; each ack_o is a single-cycle pulse.
- Channel 0 drops req_i 2 cycles into BUSY, ack arrives 3 cycles later -> edn_req_o held through the ack, no ack_o, drop_cnt_o=1, state back to IDLE; a pending req_i[1] is then granted.
- escalate_i asserted mid-BUSY -> edn_req_o stays 1 until edn_ack_i, ack_o suppressed, drop_cnt_o=1, then halted_o=1 and edn_req_o=0 while req_i=3'b111 is held.
- Spurious edn_ack_i in IDLE -> err_o=1 and stays 1; ack_o=0.
- Force 2^CntWidth+3 orphaned transactions with CntWidth=2 -> drop_cnt_o saturates at 3; async reset asserted mid-BUSY -> all outputs 0 and ptr=0 immediately.
